traffic_junction: RTL and testbench
===================================

# traffic_junction

Parametrised controller for a multi-approach road junction. It drives UK-sequence red/amber/green lamps for N_WAYS approaches and grants green to one approach at a time, picked round-robin from per-approach vehicle requests. Phase durations are parameters, green is extended while no other approach is waiting, and a fault input forces flashing amber on every approach. It replaces the fixed single-approach TrafficLights block at the top level of the lights design.

## Interface
- N_WAYS, 2: number of approaches (2..8)
- T_ALL_RED, 2: clock cycles of all-red clearance between greens
- T_RED_AMBER, 2: cycles of red+amber before green
- T_GREEN_MIN, 4: minimum green cycles
- T_AMBER, 3: cycles of amber after green
- T_FLASH, 5: cycles per on/off half-period in flash mode
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_WAYS  per-approach vehicle waiting, level-sensitive, synchronous to clk
- fault  in  1  forces flash mode while high, synchronous
- red  out  N_WAYS  red lamp per approach
- amber  out  N_WAYS  amber lamp per approach
- green  out  N_WAYS  green lamp per approach
- way  out  $clog2(N_WAYS)  index of the approach currently served or last served

## Operation
- States: ALL_RED, RED_AMBER, GREEN, AMBER, FLASH. There is a single down/up phase timer, and each timed state lasts exactly T cycles (timer 0..T-1).
- Lamps of non-served approaches are red in every state except FLASH.
- ALL_RED: all red. When the timer reaches T_ALL_RED-1 or later, pick the first approach with req high, searching from way+1 upward with wrap-around. The current way is searched last. If one is found, load way and go to RED_AMBER. If no req is high, hold ALL_RED and re-evaluate every cycle.
- RED_AMBER: served approach shows red+amber. After T_RED_AMBER cycles, go to GREEN.
- GREEN: served approach shows green only. Once the timer is at T_GREEN_MIN-1 or later, go to AMBER on the first cycle where any other approach has req high. Otherwise stay green indefinitely. The timer saturates at T_GREEN_MIN-1.
- AMBER: served approach shows amber only. After T_AMBER cycles, go to ALL_RED.
- FLASH: entered from any state on the cycle after fault is sampled high. Red and green are off on all approaches. Amber on all approaches starts on and toggles every T_FLASH cycles.
- Leaving FLASH: on the cycle after fault is sampled low, go to ALL_RED with the timer cleared. way is unchanged.
- The timer clears on every state change.
- Timer width is $clog2 of the largest T parameter plus 1. No arithmetic overflow is possible.
- Exactly one of red, amber and green is high per approach, except for red+amber in RED_AMBER. No two approaches are ever non-red simultaneously outside FLASH.

## Timing
- Moore outputs, registered. Lamp outputs change only on the clock edge that changes state, or on a flash toggle.
- Reset, async assert, sync release: state ALL_RED, timer 0, way 0, red all ones, amber and green all zeros.
- Reset asserted mid-phase: lamps go to all-red immediately, without waiting for a clock edge.
- Round trip from request to green, with all other approaches idle and the junction in ALL_RED with the timer expired: req high at edge k gives red+amber from edge k+1 and green from edge k+1+T_RED_AMBER.
- fault and a phase expiry on the same cycle: fault wins.
- A request that drops before it is granted is forgotten. There is no latching.

## Structure
- Shared package traffic_pkg:
  - state encoding constants for ALL_RED, RED_AMBER, GREEN, AMBER, FLASH
  - lamp-pattern constants
- Sub-module rr_pick: combinational round-robin selector. Inputs are req, way and an exclude-current flag. Outputs are found and next_way. It is reused by the GREEN exit test (any other request) and by the ALL_RED grant.
- Top-level file holds the state register, the timer, the flash toggle and the lamp decode.

## Test plan
Defaults throughout unless stated.
- Reset and free cycle: rst_n low then high with req=2'b11. After 2 cycles, way=1 and red+amber on approach 1. Green on approach 1 starts 2 cycles later and lasts exactly 4 cycles. Then 3 cycles amber, 2 cycles all-red, then approach 0 is served.
- Green extension: req=2'b01 only while approach 0 is green. Green holds for 20+ cycles. Raising req[1] at cycle 20 gives amber on approach 0 at cycle 21.
- Idle hold: req=0 after reset. The block stays all-red with way=0 for 50 cycles.
- Fault: fault high during GREEN. The next edge shows all amber on and red and green all zero. Amber toggles every 5 cycles. Dropping fault gives all-red for 2 cycles, then a normal grant.
- Round-robin with N_WAYS=4 and req=4'b1010, starting from way=1. The grant order is 3, 1, 3, 1. Approaches 0 and 2 are never served.
- Async reset mid-AMBER: rst_n low between edges. Lamps are all red before the next edge, with way=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the junction controller: the phase encoding, the
// per-approach lamp patterns and a small helper used for parameter sizing.
package traffic_pkg;

    // Controller phases. FLASH is the fault mode; the others form the normal cycle.
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        RED_AMBER = 3'd1,
        GREEN     = 3'd2,
        AMBER     = 3'd3,
        FLASH     = 3'd4
    } state_t;

    // One approach's lamp head.
    typedef struct packed {
        logic red;
        logic amber;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_OFF       = 3'b000;
    localparam lamp_t LAMP_RED       = 3'b100;
    localparam lamp_t LAMP_RED_AMBER = 3'b110;
    localparam lamp_t LAMP_GREEN     = 3'b001;
    localparam lamp_t LAMP_AMBER     = 3'b010;

    // Lamp pattern of the served approach in a non-flash phase.
    function automatic lamp_t served_lamp(input state_t s);
        lamp_t l;
        case (s)
            RED_AMBER: l = LAMP_RED_AMBER;
            GREEN:     l = LAMP_GREEN;
            AMBER:     l = LAMP_AMBER;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first approach with req high, searching upward from
// way+1 with wrap-around. The current way is the last candidate, and is
// skipped entirely when exclude_cur is set.
module rr_pick #(
    parameter int N_WAYS = 2,
    localparam int WW    = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-1:0] req,
    input  logic [WW-1:0]     way,
    input  logic              exclude_cur,
    output logic              found,
    output logic [WW-1:0]     next_way
);

    // Walk offsets from furthest to nearest so the nearest hit wins.
    always_comb begin
        int idx;
        found    = 1'b0;
        next_way = way;
        idx      = 0;
        for (int off = N_WAYS; off >= 1; off--) begin
            idx = (int'(way) + off) % N_WAYS;
            if (req[idx] && !(exclude_cur && (off == N_WAYS))) begin
                found    = 1'b1;
                next_way = WW'(idx);
            end
        end
    end

endmodule

// File: rtl/traffic_junction.sv
// Multi-approach junction controller. Holds the phase register, the shared
// phase timer, the flash toggle and the registered lamp decode. Lamps are
// decoded from next-state values so they change on the same edge as the phase.
module traffic_junction #(
    parameter int N_WAYS      = 2,
    parameter int T_ALL_RED   = 2,
    parameter int T_RED_AMBER = 2,
    parameter int T_GREEN_MIN = 4,
    parameter int T_AMBER     = 3,
    parameter int T_FLASH     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_WAYS-1:0]         req,
    input  logic                      fault,
    output logic [N_WAYS-1:0]         red,
    output logic [N_WAYS-1:0]         amber,
    output logic [N_WAYS-1:0]         green,
    output logic [$clog2(N_WAYS)-1:0] way
);
    import traffic_pkg::*;

    localparam int WW    = $clog2(N_WAYS);
    localparam int T_MAX = max_int(max_int(max_int(T_ALL_RED, T_RED_AMBER),
                                           max_int(T_GREEN_MIN, T_AMBER)), T_FLASH);
    localparam int TW    = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] LAST_ALL_RED   = TW'(T_ALL_RED - 1);
    localparam logic [TW-1:0] LAST_RED_AMBER = TW'(T_RED_AMBER - 1);
    localparam logic [TW-1:0] LAST_GREEN_MIN = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] LAST_AMBER     = TW'(T_AMBER - 1);
    localparam logic [TW-1:0] LAST_FLASH     = TW'(T_FLASH - 1);
    localparam logic [TW-1:0] TIMER_ONE      = TW'(1);

    state_t            state, n_state;
    logic [TW-1:0]     timer, n_timer;
    logic [WW-1:0]     n_way;
    logic              flash_on, n_flash;
    logic [N_WAYS-1:0] n_red, n_amber, n_green;
    logic              pick_found;
    logic [WW-1:0]     pick_way;

    // In GREEN the picker answers "is anyone else waiting"; in ALL_RED it grants.
    rr_pick #(.N_WAYS(N_WAYS)) u_pick (
        .req         (req),
        .way         (way),
        .exclude_cur (state == GREEN),
        .found       (pick_found),
        .next_way    (pick_way)
    );

    // Next phase, timer, served way and flash level; fault overrides everything.
    always_comb begin
        n_state = state;
        n_timer = timer;
        n_way   = way;
        n_flash = flash_on;
        if (fault) begin
            if (state != FLASH) begin
                n_state = FLASH;
                n_timer = '0;
                n_flash = 1'b1;
            end else if (timer >= LAST_FLASH) begin
                n_timer = '0;
                n_flash = ~flash_on;
            end else begin
                n_timer = timer + TIMER_ONE;
            end
        end else begin
            case (state)
                ALL_RED: begin
                    if (timer >= LAST_ALL_RED && pick_found) begin
                        n_state = RED_AMBER;
                        n_timer = '0;
                        n_way   = pick_way;
                    end else if (timer < LAST_ALL_RED) begin
                        n_timer = timer + TIMER_ONE;
                    end
                end
                RED_AMBER: begin
                    if (timer >= LAST_RED_AMBER) begin
                        n_state = GREEN;
                        n_timer = '0;
                    end else begin
                        n_timer = timer + TIMER_ONE;
                    end
                end
                GREEN: begin
                    if (timer >= LAST_GREEN_MIN) begin
                        if (pick_found) begin
                            n_state = AMBER;
                            n_timer = '0;
                        end
                    end else begin
                        n_timer = timer + TIMER_ONE;
                    end
                end
                AMBER: begin
                    if (timer >= LAST_AMBER) begin
                        n_state = ALL_RED;
                        n_timer = '0;
                    end else begin
                        n_timer = timer + TIMER_ONE;
                    end
                end
                FLASH: begin
                    n_state = ALL_RED;
                    n_timer = '0;
                    n_flash = 1'b0;
                end
                default: begin
                    n_state = ALL_RED;
                    n_timer = '0;
                end
            endcase
        end
    end

    // Lamp decode of the next phase so the outputs can be registered.
    always_comb begin
        lamp_t l;
        n_red   = '0;
        n_amber = '0;
        n_green = '0;
        l       = LAMP_RED;
        for (int i = 0; i < N_WAYS; i++) begin
            if (n_state == FLASH) begin
                l = n_flash ? LAMP_AMBER : LAMP_OFF;
            end else if (WW'(i) == n_way) begin
                l = served_lamp(n_state);
            end else begin
                l = LAMP_RED;
            end
            n_red[i]   = l.red;
            n_amber[i] = l.amber;
            n_green[i] = l.green;
        end
    end

    // Phase register and registered lamps; reset forces all-red at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ALL_RED;
            timer    <= '0;
            way      <= '0;
            flash_on <= 1'b0;
            red      <= '1;
            amber    <= '0;
            green    <= '0;
        end else begin
            state    <= n_state;
            timer    <= n_timer;
            way      <= n_way;
            flash_on <= n_flash;
            red      <= n_red;
            amber    <= n_amber;
            green    <= n_green;
        end
    end

endmodule

// File: tb/tb_traffic_junction.sv
// Bench for traffic_junction: a 2-way and a 4-way instance share clock and
// reset. Directed table, hand sequences for the multi-cycle corners, then a
// randomized run checked against a phase/age reference model.
module tb_traffic_junction;

    localparam int T_ALL_RED   = 2;
    localparam int T_RED_AMBER = 2;
    localparam int T_GREEN_MIN = 4;
    localparam int T_AMBER     = 3;
    localparam int T_FLASH     = 5;

    localparam int P_CLEAR = 0;
    localparam int P_PREP  = 1;
    localparam int P_GO    = 2;
    localparam int P_STOP  = 3;
    localparam int P_FLASH = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req2 = '0;
    logic       fault2 = 1'b0;
    logic [1:0] red2, amber2, green2;
    logic       way2;

    logic [3:0] req4 = '0;
    logic       fault4 = 1'b0;
    logic [3:0] red4, amber4, green4;
    logic [1:0] way4;

    traffic_junction #(.N_WAYS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .fault(fault2),
        .red(red2), .amber(amber2), .green(green2), .way(way2)
    );

    traffic_junction #(.N_WAYS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .fault(fault4),
        .red(red4), .amber(amber4), .green(green4), .way(way4)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Phase plus age (edges since entering the phase); flash level derived
    // from elapsed time in flash rather than a toggle register.
    typedef struct {
        int phase;
        int age;
        int way;
    } model_t;

    model_t m2, m4;

    function automatic model_t model_reset();
        model_t r;
        r.phase = P_CLEAR;
        r.age   = 0;
        r.way   = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, int n, logic [7:0] rq, logic f);
        model_t r;
        logic [7:0] others;
        bit got;
        r = m;
        got = 1'b0;
        if (f) begin
            if (m.phase != P_FLASH) begin
                r.phase = P_FLASH;
                r.age   = 0;
            end else begin
                r.age = m.age + 1;
            end
            return r;
        end
        if (m.phase == P_FLASH) begin
            r.phase = P_CLEAR;
            r.age   = 0;
            return r;
        end
        r.age = m.age + 1;
        case (m.phase)
            P_CLEAR: if (m.age >= T_ALL_RED - 1) begin
                for (int k = 1; k <= n; k++) begin
                    if (!got && rq[(m.way + k) % n]) begin
                        got     = 1'b1;
                        r.way   = (m.way + k) % n;
                        r.phase = P_PREP;
                        r.age   = 0;
                    end
                end
            end
            P_PREP: if (m.age == T_RED_AMBER - 1) begin
                r.phase = P_GO;
                r.age   = 0;
            end
            P_GO: begin
                others = rq & ((8'd1 << n) - 8'd1) & ~(8'd1 << m.way);
                if (m.age >= T_GREEN_MIN - 1 && others != 8'd0) begin
                    r.phase = P_STOP;
                    r.age   = 0;
                end
            end
            P_STOP: if (m.age == T_AMBER - 1) begin
                r.phase = P_CLEAR;
                r.age   = 0;
            end
            default: r.phase = P_CLEAR;
        endcase
        return r;
    endfunction

    // Returns {red[7:0], amber[7:0], green[7:0]}.
    function automatic logic [23:0] model_lamps(model_t m, int n);
        logic [7:0] r, a, g;
        r = '0;
        a = '0;
        g = '0;
        for (int i = 0; i < n; i++) begin
            if (m.phase == P_FLASH) begin
                a[i] = (((m.age / T_FLASH) % 2) == 0);
            end else if (i != m.way) begin
                r[i] = 1'b1;
            end else begin
                case (m.phase)
                    P_CLEAR: r[i] = 1'b1;
                    P_PREP:  begin r[i] = 1'b1; a[i] = 1'b1; end
                    P_GO:    g[i] = 1'b1;
                    P_STOP:  a[i] = 1'b1;
                    default: r[i] = 1'b1;
                endcase
            end
        end
        return {r, a, g};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m2 = model_reset();
        m4 = model_reset();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0] rq;
        logic       f;
        logic [1:0] r;
        logic [1:0] a;
        logic [1:0] g;
        logic       w;
    } vec_t;

    vec_t tbl[24];

    task automatic put(input int lo, input int hi, input logic [1:0] rq, input logic f,
                       input logic [1:0] r, input logic [1:0] a, input logic [1:0] g,
                       input logic w);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].rq = rq; tbl[i].f = f;
            tbl[i].r = r; tbl[i].a = a; tbl[i].g = g; tbl[i].w = w;
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [1:0]  exp_q[$];
    logic [3:0]  prev_prep;
    logic [23:0] lm;
    int          f2_hold, f4_hold;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Row i holds inputs applied before edge i+1 and outputs after it.
        put(0,  0,  2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        put(1,  2,  2'b11, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1);
        put(3,  6,  2'b11, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1);
        put(7,  9,  2'b11, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1);
        put(10, 11, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1);
        put(12, 13, 2'b11, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0);
        put(14, 14, 2'b11, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0);
        put(15, 19, 2'b11, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0);
        put(20, 20, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        put(21, 22, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        put(23, 23, 2'b11, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1);

        // Reset state, then free-running cycle with fault excursion.
        req2 = 2'b11;
        rst_n = 1'b0;
        tick();
        check("reset_lamps2", {red2, amber2, green2, way2}, {2'b11, 2'b00, 2'b00, 1'b0});
        check("reset_lamps4", {red4, amber4, green4, way4}, {4'hf, 4'h0, 4'h0, 2'd0});
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req2   = tbl[i].rq;
            fault2 = tbl[i].f;
            tick();
            check($sformatf("table_row%0d", i), {red2, amber2, green2, way2},
                  {tbl[i].r, tbl[i].a, tbl[i].g, tbl[i].w});
        end
        fault2 = 1'b0;

        // Green extension: only approach 0 waiting.
        req2 = 2'b01;
        do_reset();
        for (int c = 0; c < 30 && green2 != 2'b01; c++) tick();
        check("ext_reach_green", {30'd0, green2}, {30'd0, 2'b01});
        for (int c = 0; c < 22; c++) begin
            tick();
            check("ext_green_hold", {red2, amber2, green2}, {2'b10, 2'b00, 2'b01});
        end
        req2 = 2'b11;
        tick();
        check("ext_amber_after_req", {red2, amber2, green2}, {2'b10, 2'b01, 2'b00});

        // Idle hold: no requests, stays all-red on way 0.
        req2 = 2'b00;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            tick();
            check("idle_hold", {red2, amber2, green2, way2}, {2'b11, 2'b00, 2'b00, 1'b0});
        end

        // Round-robin on the 4-way instance: requests on 1 and 3 only.
        req4 = 4'b1010;
        do_reset();
        exp_q = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        prev_prep = '0;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            tick();
            check("rr_unserved_red", {30'd0, red4[2], red4[0]}, {30'd0, 2'b11});
            if ((red4 & amber4) != 4'd0 && prev_prep == 4'd0) begin
                check("rr_order", {30'd0, way4}, {30'd0, exp_q.pop_front()});
            end
            prev_prep = red4 & amber4;
        end
        check("rr_all_grants_seen", exp_q.size(), 0);
        req4 = 4'b0000;

        // Async reset asserted between edges during AMBER of approach 1.
        req2 = 2'b11;
        do_reset();
        for (int c = 0; c < 40 && !(amber2 == 2'b10 && red2 == 2'b01); c++) tick();
        check("async_reach_amber", {28'd0, red2, amber2}, {28'd0, 2'b01, 2'b10});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_lamps", {red2, amber2, green2, way2}, {2'b11, 2'b00, 2'b00, 1'b0});
        tick();

        // Randomized run against the reference model on both instances.
        do_reset();
        f2_hold = 0;
        f4_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) req4 = 4'($urandom_range(0, 15));
            if (f2_hold > 0) begin
                f2_hold--;
                fault2 = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                f2_hold = $urandom_range(1, 14);
                fault2 = 1'b1;
            end else begin
                fault2 = 1'b0;
            end
            if (f4_hold > 0) begin
                f4_hold--;
                fault4 = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                f4_hold = $urandom_range(1, 14);
                fault4 = 1'b1;
            end else begin
                fault4 = 1'b0;
            end
            tick();
            m2 = model_step(m2, 2, {6'd0, req2}, fault2);
            lm = model_lamps(m2, 2);
            check("rand_way2", {red2, amber2, green2, way2},
                  {lm[17:16], lm[9:8], lm[1:0], m2.way[0]});
            m4 = model_step(m4, 4, {4'd0, req4}, fault4);
            lm = model_lamps(m4, 4);
            check("rand_way4", {red4, amber4, green4, way4},
                  {lm[19:16], lm[11:8], lm[3:0], m4.way[1:0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
